gemm_tile_ctrl: RTL and testbench
=================================

Name: gemm_tile_ctrl

Overview:
Sequencer for the GEMM systolic-array datapath: runs a configurable number of weight-stationary tiles end to end.
- Per tile: issues the weight reads and generates b_path_en while the weights shift into the array.
- Streams the input rows and generates the diagonal b_en window.
- Issues the accumulator read/write addresses for the deskewed output rows.
- Sits between the host/config registers and the memories plus systolic_array, replacing the ad-hoc per-step FSMs in gemm.

Parameters:
ARRAY_N, 8, array columns / weight words per tile
ARRAY_M, 8, input rows per tile
INP_MEM_ADDR_WIDTH_W, 12, input memory address width
WGT_MEM_ADDR_WIDTH_W, 13, weight memory address width
ACC_MEM_ADDR_WIDTH_W, 12, accumulator memory address width
MEM_RD_LAT, 1, memory read latency in cycles (>=1)
OUT_LAT, ARRAY_N+ARRAY_M+1, COMPUTE-relative cycle at which deskewed output row 0 is valid (must be >= MEM_RD_LAT)
TILE_CNT_W, 8, tile counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  start pulse, sampled only in IDLE
abort  in  1  synchronous abort
cfg_num_tiles  in  TILE_CNT_W  tiles to run
cfg_inp_base  in  INP_MEM_ADDR_WIDTH_W  input base address
cfg_wgt_base  in  WGT_MEM_ADDR_WIDTH_W  weight base address
cfg_acc_base  in  ACC_MEM_ADDR_WIDTH_W  accumulator base address
cfg_accumulate  in  1  1 = read-modify-write acc, 0 = overwrite
busy  out  1  high outside IDLE
done  out  1  one-cycle completion pulse
inp_mem_read_ADDR  out  INP_MEM_ADDR_WIDTH_W  input read address
inp_mem_read_EN  out  1  input read enable
wgt_mem_read_ADDR  out  WGT_MEM_ADDR_WIDTH_W  weight read address
wgt_mem_read_EN  out  1  weight read enable
acc_mem_read_ADDR  out  ACC_MEM_ADDR_WIDTH_W  accumulator read address
acc_mem_read_EN  out  1  accumulator read enable
acc_mem_write_ADDR  out  ACC_MEM_ADDR_WIDTH_W  accumulator write address
acc_mem_write_EN  out  1  accumulator write enable
acc_add_en  out  1  datapath adds the read-back value (registered copy of cfg_accumulate)
b_path_en  out  ARRAY_N  weight shift-path enable, thermometer
b_en  out  ARRAY_N  per-column compute enable

Behaviour:
- Reset (async, reset_n low):
  - State IDLE; all outputs and counters 0.
  - Reset mid-run abandons the run; no done pulse.
- All outputs are registered.
- Address wrap is modulo the port width; there is no overflow flag.
- States: IDLE, LOAD_WGT, WGT_WAIT, COMPUTE.
- IDLE:
  - start=1 latches all cfg_* values and sets tile t=0.
  - If cfg_num_tiles==0: done pulses the next cycle, no memory accesses, stay in IDLE.
  - Otherwise go to LOAD_WGT.
- start while busy is ignored. cfg_* changes while busy have no effect.
- LOAD_WGT, ARRAY_N cycles, index k:
  - wgt_mem_read_EN=1.
  - wgt_mem_read_ADDR = wgt_base + t*ARRAY_N + k.
- WGT_WAIT: MEM_RD_LAT cycles, no reads.
- b_path_en across LOAD_WGT+WGT_WAIT, phase cycle i = 0..ARRAY_N+MEM_RD_LAT-1:
  - value is a thermometer with max(0, i-MEM_RD_LAT+1) ones, LSB first.
  - 0 in all other states.
- COMPUTE: counter c = 0..OUT_LAT+ARRAY_M-1.
  - Input reads: for c<ARRAY_M, inp_mem_read_EN=1 and inp_mem_read_ADDR = inp_base + t*ARRAY_M + c.
  - b_en[j] = 1 for MEM_RD_LAT+j <= c < MEM_RD_LAT+j+ARRAY_M; 0 otherwise.
  - Acc reads: if acc_add_en, acc_mem_read_EN=1 at c = OUT_LAT-MEM_RD_LAT+r for r = 0..ARRAY_M-1, with acc_mem_read_ADDR = acc_base + t*ARRAY_M + r.
  - Acc writes: acc_mem_write_EN=1 at c = OUT_LAT+r, same address.
- Last COMPUTE cycle:
  - If t+1 < num_tiles: t++, go to LOAD_WGT. No bubble cycle.
  - Else go to IDLE; done=1 for exactly the first IDLE cycle.
- abort=1 in any non-IDLE state:
  - Next cycle IDLE; all enables, b_en and b_path_en 0; no done.
  - abort takes priority over start in the same cycle.
- Per-tile length: ARRAY_N + MEM_RD_LAT + OUT_LAT + ARRAY_M cycles.

Decomposition:
- Shared package gemm_pkg:
  - state encoding localparams (IDLE=0, LOAD_WGT=1, WGT_WAIT=2, COMPUTE=3);
  - default array dimensions and address widths.
- One sub-module: gemm_en_gen. It takes the phase counter and generates the b_path_en thermometer and the diagonal b_en window, and is reusable by the datapath testbench.
- The FSM and address counters stay in the top.

Test Plan:
(All cases use ARRAY_N=ARRAY_M=4, MEM_RD_LAT=1, OUT_LAT=9.)
1. Single tile: start with num_tiles=1, wgt_base=0x100 -> wgt reads at 0x100..0x103 on cycles 1-4; b_path_en 0000,0001,0011,0111,1111 on cycles 1-5; done pulses on cycle 19.
2. b_en window: same run -> b_en[0] high at COMPUTE c=1..4 and b_en[3] at c=4..7; inp reads at inp_base+0..3 on c=0..3.
3. Accumulate, 2 tiles: acc_base=0x20, cfg_accumulate=1 -> acc reads at 0x20..0x23 on c=8..11 and writes on c=9..12; tile 1 uses 0x24..0x27 and wgt_base+4; done 37 cycles after start.
4. Overwrite mode: cfg_accumulate=0 -> acc_mem_read_EN never high; writes still issued.
5. num_tiles=0 -> done one cycle after start; no EN asserted. start asserted during busy -> ignored.
6. abort at COMPUTE c=5 -> all EN, b_en and b_path_en 0 next cycle, no done, busy=0. Async reset_n low mid-LOAD_WGT -> outputs 0 immediately.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and default geometry for the GEMM tile sequencer and its datapath.
package gemm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_WGT = 2'd1,
        WGT_WAIT = 2'd2,
        COMPUTE  = 2'd3
    } gemm_state_e;

    localparam int DEF_ARRAY_N              = 8;
    localparam int DEF_ARRAY_M              = 8;
    localparam int DEF_INP_MEM_ADDR_WIDTH_W = 12;
    localparam int DEF_WGT_MEM_ADDR_WIDTH_W = 13;
    localparam int DEF_ACC_MEM_ADDR_WIDTH_W = 12;
    localparam int DEF_MEM_RD_LAT           = 1;
    localparam int DEF_TILE_CNT_W           = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gemm_tile_ctrl_if.sv
// Host/config and memory-side signals of the tile sequencer; master is the sequencer side.
interface gemm_tile_ctrl_if
    import gemm_pkg::*;
#(
    parameter int ARRAY_N              = DEF_ARRAY_N,
    parameter int TILE_CNT_W           = DEF_TILE_CNT_W,
    parameter int INP_MEM_ADDR_WIDTH_W = DEF_INP_MEM_ADDR_WIDTH_W,
    parameter int WGT_MEM_ADDR_WIDTH_W = DEF_WGT_MEM_ADDR_WIDTH_W,
    parameter int ACC_MEM_ADDR_WIDTH_W = DEF_ACC_MEM_ADDR_WIDTH_W
);
    logic                            start;
    logic                            abort;
    logic [TILE_CNT_W-1:0]           cfg_num_tiles;
    logic [INP_MEM_ADDR_WIDTH_W-1:0] cfg_inp_base;
    logic [WGT_MEM_ADDR_WIDTH_W-1:0] cfg_wgt_base;
    logic [ACC_MEM_ADDR_WIDTH_W-1:0] cfg_acc_base;
    logic                            cfg_accumulate;

    logic                            busy;
    logic                            done;
    logic [INP_MEM_ADDR_WIDTH_W-1:0] inp_mem_read_ADDR;
    logic                            inp_mem_read_EN;
    logic [WGT_MEM_ADDR_WIDTH_W-1:0] wgt_mem_read_ADDR;
    logic                            wgt_mem_read_EN;
    logic [ACC_MEM_ADDR_WIDTH_W-1:0] acc_mem_read_ADDR;
    logic                            acc_mem_read_EN;
    logic [ACC_MEM_ADDR_WIDTH_W-1:0] acc_mem_write_ADDR;
    logic                            acc_mem_write_EN;
    logic                            acc_add_en;
    logic [ARRAY_N-1:0]              b_path_en;
    logic [ARRAY_N-1:0]              b_en;

    modport master (
        input  start, abort, cfg_num_tiles, cfg_inp_base, cfg_wgt_base, cfg_acc_base,
               cfg_accumulate,
        output busy, done, inp_mem_read_ADDR, inp_mem_read_EN, wgt_mem_read_ADDR,
               wgt_mem_read_EN, acc_mem_read_ADDR, acc_mem_read_EN, acc_mem_write_ADDR,
               acc_mem_write_EN, acc_add_en, b_path_en, b_en
    );

    modport slave (
        output start, abort, cfg_num_tiles, cfg_inp_base, cfg_wgt_base, cfg_acc_base,
               cfg_accumulate,
        input  busy, done, inp_mem_read_ADDR, inp_mem_read_EN, wgt_mem_read_ADDR,
               wgt_mem_read_EN, acc_mem_read_ADDR, acc_mem_read_EN, acc_mem_write_ADDR,
               acc_mem_write_EN, acc_add_en, b_path_en, b_en
    );

endinterface

// File: rtl/gemm_en_gen.sv
// Weight shift-path thermometer and diagonal per-column compute window, decoded from state + phase.
module gemm_en_gen
    import gemm_pkg::*;
#(
    parameter int ARRAY_N    = DEF_ARRAY_N,
    parameter int ARRAY_M    = DEF_ARRAY_M,
    parameter int MEM_RD_LAT = DEF_MEM_RD_LAT,
    parameter int PH_W       = 5
) (
    input  gemm_state_e       state,
    input  logic [PH_W-1:0]   phase,
    output logic [ARRAY_N-1:0] b_path_en,
    output logic [ARRAY_N-1:0] b_en
);

    // Column j's weight arrives MEM_RD_LAT cycles after its read; its inputs arrive skewed by j.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        b_path_en = '0;
        b_en      = '0;
        for (int j = 0; j < ARRAY_N; j++) begin
            if ((state == LOAD_WGT || state == WGT_WAIT) && int'(phase) >= MEM_RD_LAT + j)
                b_path_en[j] = 1'b1;
            if (state == COMPUTE && int'(phase) >= MEM_RD_LAT + j &&
                int'(phase) < MEM_RD_LAT + j + ARRAY_M)
                b_en[j] = 1'b1;
        end
    end

endmodule

// File: rtl/gemm_tile_ctrl.sv
// Tile sequencer: weight load, input streaming and accumulator addressing for back-to-back tiles.
module gemm_tile_ctrl
    import gemm_pkg::*;
#(
    parameter int ARRAY_N              = DEF_ARRAY_N,
    parameter int ARRAY_M              = DEF_ARRAY_M,
    parameter int INP_MEM_ADDR_WIDTH_W = DEF_INP_MEM_ADDR_WIDTH_W,
    parameter int WGT_MEM_ADDR_WIDTH_W = DEF_WGT_MEM_ADDR_WIDTH_W,
    parameter int ACC_MEM_ADDR_WIDTH_W = DEF_ACC_MEM_ADDR_WIDTH_W,
    parameter int MEM_RD_LAT           = DEF_MEM_RD_LAT,
    parameter int OUT_LAT              = ARRAY_N + ARRAY_M + 1,
    parameter int TILE_CNT_W           = DEF_TILE_CNT_W
) (
    input logic clk,
    input logic reset_n,
    gemm_tile_ctrl_if.master bus
);

    localparam int INP_W  = INP_MEM_ADDR_WIDTH_W;
    localparam int WGT_W  = WGT_MEM_ADDR_WIDTH_W;
    localparam int ACC_W  = ACC_MEM_ADDR_WIDTH_W;
    localparam int PH_MAX = max_int(ARRAY_N + MEM_RD_LAT, OUT_LAT + ARRAY_M) - 1;
    localparam int PH_W   = max_int($clog2(PH_MAX + 1), 1);

    localparam logic [PH_W-1:0] LOAD_END  = PH_W'(ARRAY_N - 1);
    localparam logic [PH_W-1:0] WAIT_END  = PH_W'(ARRAY_N + MEM_RD_LAT - 1);
    localparam logic [PH_W-1:0] COMP_END  = PH_W'(OUT_LAT + ARRAY_M - 1);
    localparam logic [PH_W-1:0] INP_END   = PH_W'(ARRAY_M);
    localparam logic [PH_W-1:0] ACC_RD_LO = PH_W'(OUT_LAT - MEM_RD_LAT);
    localparam logic [PH_W-1:0] ACC_RD_HI = PH_W'(OUT_LAT - MEM_RD_LAT + ARRAY_M);
    localparam logic [PH_W-1:0] ACC_WR_LO = PH_W'(OUT_LAT);

    gemm_state_e           state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [TILE_CNT_W-1:0] tile_q, tile_d, num_tiles_q, num_tiles_d;
    logic                  acc_add_q, acc_add_d;
    logic [WGT_W-1:0]      wgt_tile_q, wgt_tile_d;
    logic [INP_W-1:0]      inp_tile_q, inp_tile_d;
    logic [ACC_W-1:0]      acc_tile_q, acc_tile_d;

    logic                  busy_q, busy_d, done_q, done_d;
    logic                  wgt_en_q, wgt_en_d, inp_en_q, inp_en_d;
    logic                  acc_rd_en_q, acc_rd_en_d, acc_wr_en_q, acc_wr_en_d;
    logic [WGT_W-1:0]      wgt_addr_q, wgt_addr_d;
    logic [INP_W-1:0]      inp_addr_q, inp_addr_d;
    logic [ACC_W-1:0]      acc_rd_addr_q, acc_rd_addr_d, acc_wr_addr_q, acc_wr_addr_d;
    logic [ARRAY_N-1:0]    b_path_q, b_path_d, b_en_q, b_en_d;

    // Tile bases advance by one tile per pass, so addresses are base + phase with no multiply.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        tile_d      = tile_q;
        num_tiles_d = num_tiles_q;
        acc_add_d   = acc_add_q;
        wgt_tile_d  = wgt_tile_q;
        inp_tile_d  = inp_tile_q;
        acc_tile_d  = acc_tile_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    num_tiles_d = bus.cfg_num_tiles;
                    acc_add_d   = bus.cfg_accumulate;
                    wgt_tile_d  = bus.cfg_wgt_base;
                    inp_tile_d  = bus.cfg_inp_base;
                    acc_tile_d  = bus.cfg_acc_base;
                    tile_d      = '0;
                    phase_d     = '0;
                    if (bus.cfg_num_tiles == '0) done_d = 1'b1;
                    else                         state_d = LOAD_WGT;
                end
            end
            LOAD_WGT: begin
                phase_d = phase_q + PH_W'(1);
                if (phase_q == LOAD_END) state_d = WGT_WAIT;
            end
            WGT_WAIT: begin
                phase_d = phase_q + PH_W'(1);
                if (phase_q == WAIT_END) begin
                    state_d = COMPUTE;
                    phase_d = '0;
                end
            end
            COMPUTE: begin
                phase_d = phase_q + PH_W'(1);
                if (phase_q == COMP_END) begin
                    phase_d = '0;
                    if (tile_q != num_tiles_q - TILE_CNT_W'(1)) begin
                        state_d    = LOAD_WGT;
                        tile_d     = tile_q + TILE_CNT_W'(1);
                        wgt_tile_d = wgt_tile_q + WGT_W'(ARRAY_N);
                        inp_tile_d = inp_tile_q + INP_W'(ARRAY_M);
                        acc_tile_d = acc_tile_q + ACC_W'(ARRAY_M);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            phase_d = '0;
            done_d  = 1'b0;
        end

        // Outputs are decoded from the next state so the registered copies line up with it.
        busy_d        = (state_d != IDLE);
        wgt_en_d      = (state_d == LOAD_WGT);
        wgt_addr_d    = wgt_en_d ? wgt_tile_d + WGT_W'(phase_d) : '0;
        inp_en_d      = (state_d == COMPUTE) && (phase_d < INP_END);
        inp_addr_d    = inp_en_d ? inp_tile_d + INP_W'(phase_d) : '0;
        acc_rd_en_d   = (state_d == COMPUTE) && acc_add_d &&
                        (phase_d >= ACC_RD_LO) && (phase_d < ACC_RD_HI);
        acc_rd_addr_d = acc_rd_en_d ? acc_tile_d + ACC_W'(phase_d - ACC_RD_LO) : '0;
        acc_wr_en_d   = (state_d == COMPUTE) && (phase_d >= ACC_WR_LO);
        acc_wr_addr_d = acc_wr_en_d ? acc_tile_d + ACC_W'(phase_d - ACC_WR_LO) : '0;
    end

    gemm_en_gen #(
        .ARRAY_N    (ARRAY_N),
        .ARRAY_M    (ARRAY_M),
        .MEM_RD_LAT (MEM_RD_LAT),
        .PH_W       (PH_W)
    ) u_en_gen (
        .state     (state_d),
        .phase     (phase_d),
        .b_path_en (b_path_d),
        .b_en      (b_en_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            tile_q        <= '0;
            num_tiles_q   <= '0;
            acc_add_q     <= 1'b0;
            wgt_tile_q    <= '0;
            inp_tile_q    <= '0;
            acc_tile_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wgt_en_q      <= 1'b0;
            wgt_addr_q    <= '0;
            inp_en_q      <= 1'b0;
            inp_addr_q    <= '0;
            acc_rd_en_q   <= 1'b0;
            acc_rd_addr_q <= '0;
            acc_wr_en_q   <= 1'b0;
            acc_wr_addr_q <= '0;
            b_path_q      <= '0;
            b_en_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            phase_q       <= phase_d;
            tile_q        <= tile_d;
            num_tiles_q   <= num_tiles_d;
            acc_add_q     <= acc_add_d;
            wgt_tile_q    <= wgt_tile_d;
            inp_tile_q    <= inp_tile_d;
            acc_tile_q    <= acc_tile_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wgt_en_q      <= wgt_en_d;
            wgt_addr_q    <= wgt_addr_d;
            inp_en_q      <= inp_en_d;
            inp_addr_q    <= inp_addr_d;
            acc_rd_en_q   <= acc_rd_en_d;
            acc_rd_addr_q <= acc_rd_addr_d;
            acc_wr_en_q   <= acc_wr_en_d;
            acc_wr_addr_q <= acc_wr_addr_d;
            b_path_q      <= b_path_d;
            b_en_q        <= b_en_d;
        end
    end

    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.wgt_mem_read_EN    = wgt_en_q;
    assign bus.wgt_mem_read_ADDR  = wgt_addr_q;
    assign bus.inp_mem_read_EN    = inp_en_q;
    assign bus.inp_mem_read_ADDR  = inp_addr_q;
    assign bus.acc_mem_read_EN    = acc_rd_en_q;
    assign bus.acc_mem_read_ADDR  = acc_rd_addr_q;
    assign bus.acc_mem_write_EN   = acc_wr_en_q;
    assign bus.acc_mem_write_ADDR = acc_wr_addr_q;
    assign bus.acc_add_en         = acc_add_q;
    assign bus.b_path_en          = b_path_q;
    assign bus.b_en               = b_en_q;

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// Bench for gemm_tile_ctrl at N=M=4, MEM_RD_LAT=1, OUT_LAT=9: vector table plus access scoreboard.
module tb_gemm_tile_ctrl;

    localparam int N  = 4;
    localparam int M  = 4;
    localparam int L  = 1;
    localparam int OL = 9;
    localparam int P  = N + L + OL + M;
    localparam int WMASK = 'h1FFF;
    localparam int IMASK = 'hFFF;
    localparam int AMASK = 'hFFF;

    typedef struct {
        int num; int wgt; int inp; int acc; bit accum;
        int abort_cyc; int poke_cyc; int done_cyc; int run_cycles;
    } vec_t;

    typedef struct { int kind; int cyc; int addr; } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    ev_t  sb[$];
    vec_t vecs[6];

    gemm_tile_ctrl_if #(
        .ARRAY_N(N), .TILE_CNT_W(8), .INP_MEM_ADDR_WIDTH_W(12),
        .WGT_MEM_ADDR_WIDTH_W(13), .ACC_MEM_ADDR_WIDTH_W(12)
    ) bus ();

    gemm_tile_ctrl #(
        .ARRAY_N(N), .ARRAY_M(M), .INP_MEM_ADDR_WIDTH_W(12), .WGT_MEM_ADDR_WIDTH_W(13),
        .ACC_MEM_ADDR_WIDTH_W(12), .MEM_RD_LAT(L), .OUT_LAT(OL), .TILE_CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void add_ev(input int kind, input int cyc, input int addr, input int last);
        ev_t e;
        if (cyc > last) return;
        e.kind = kind; e.cyc = cyc; e.addr = addr;
        sb.push_back(e);
    endfunction

    function automatic int last_active(input vec_t v);
        return (v.abort_cyc > 0) ? v.abort_cyc : v.num * P;
    endfunction

    function automatic void push_events(input vec_t v);
        int last = last_active(v);
        for (int t = 0; t < v.num; t++) begin
            int b = 1 + t * P;
            for (int k = 0; k < N; k++)
                add_ev(0, b + k, (v.wgt + t * N + k) & WMASK, last);
            for (int c = 0; c < M; c++)
                add_ev(1, b + N + L + c, (v.inp + t * M + c) & IMASK, last);
            for (int r = 0; r < M; r++) begin
                if (v.accum) add_ev(2, b + N + L + OL - L + r, (v.acc + t * M + r) & AMASK, last);
                add_ev(3, b + N + L + OL + r, (v.acc + t * M + r) & AMASK, last);
            end
        end
    endfunction

    function automatic longint port_val(input int kind);
        logic en; int addr;
        case (kind)
            0:       begin en = bus.wgt_mem_read_EN;  addr = int'(bus.wgt_mem_read_ADDR);  end
            1:       begin en = bus.inp_mem_read_EN;  addr = int'(bus.inp_mem_read_ADDR);  end
            2:       begin en = bus.acc_mem_read_EN;  addr = int'(bus.acc_mem_read_ADDR);  end
            default: begin en = bus.acc_mem_write_EN; addr = int'(bus.acc_mem_write_ADDR); end
        endcase
        return en ? (64'h1_0000_0000 | longint'(addr)) : 64'd0;
    endfunction

    task automatic check_ports(input int cyc);
        string names[4] = '{"wgt_rd", "inp_rd", "acc_rd", "acc_wr"};
        for (int k = 0; k < 4; k++) begin
            longint exp = 0;
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].kind == k && sb[i].cyc == cyc) begin
                    exp = 64'h1_0000_0000 | longint'(sb[i].addr);
                    sb.delete(i);
                    break;
                end
            end
            check(names[k], cyc, port_val(k), exp);
        end
    endtask

    task automatic check_model(input vec_t v, input int n);
        int  last = last_active(v);
        bit  act  = (n >= 1) && (n <= last);
        int  bp = 0, be = 0;
        if (act) begin
            int p = (n - 1) % P;
            if (p < N + L) begin
                int ones = (p - L + 1 > 0) ? p - L + 1 : 0;
                bp = (1 << ones) - 1;
            end else begin
                int c = p - (N + L);
                for (int j = 0; j < N; j++)
                    if (c >= L + j && c < L + j + M) be |= (1 << j);
            end
        end
        check("busy", n, longint'(bus.busy), longint'(act));
        check("done", n, longint'(bus.done), longint'(n == v.done_cyc));
        check("acc_add_en", n, longint'(bus.acc_add_en), longint'(v.accum));
        check("b_path_en", n, longint'(bus.b_path_en), longint'(bp));
        check("b_en", n, longint'(bus.b_en), longint'(be));
        check_ports(n);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        bus.cfg_num_tiles  = 8'(v.num);
        bus.cfg_wgt_base   = 13'(v.wgt);
        bus.cfg_inp_base   = 12'(v.inp);
        bus.cfg_acc_base   = 12'(v.acc);
        bus.cfg_accumulate = v.accum;
        bus.start          = 1'b1;
        sb.delete();
        push_events(v);
        for (int n = 1; n <= v.run_cycles; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            check_model(v, n);
            if (n == v.abort_cyc) bus.abort = 1'b1;
            if (n == v.poke_cyc) begin
                bus.start         = 1'b1;
                bus.cfg_num_tiles = 8'd3;
                bus.cfg_wgt_base  = 13'h0;
                bus.cfg_acc_base  = 12'h7F0;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("sb_leftover", v.run_cycles, longint'(sb.size()), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_num_tiles = '0; bus.cfg_inp_base = '0;
        bus.cfg_wgt_base = '0; bus.cfg_acc_base = '0; bus.cfg_accumulate = 1'b0;

        //          num  wgt     inp     acc     acc abort poke done run
        vecs[0] = '{1, 'h100,  'h040, 'h010, 1'b0, -1, -1, 19, 22};
        vecs[1] = '{2, 'h100,  'h200, 'h020, 1'b1, -1, -1, 37, 40};
        vecs[2] = '{0, 'h100,  'h000, 'h000, 1'b1, -1, -1,  1,  4};
        vecs[3] = '{1, 'h080,  'h010, 'h030, 1'b0, -1,  8, 19, 24};
        vecs[4] = '{2, 'h300,  'h300, 'h300, 1'b1, 11, -1, -1, 16};
        vecs[5] = '{3, 'h1FFE, 'hFFC, 'hFFE, 1'b1, -1, -1, 55, 58};

        repeat (3) @(negedge clk);
        check("rst_busy", 0, longint'(bus.busy), 64'd0);
        check("rst_done", 0, longint'(bus.done), 64'd0);
        check("rst_en", 0, longint'({bus.wgt_mem_read_EN, bus.inp_mem_read_EN,
              bus.acc_mem_read_EN, bus.acc_mem_write_EN, bus.acc_add_en}), 64'd0);
        check("rst_b", 0, longint'({bus.b_path_en, bus.b_en}), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // start and abort together in IDLE: abort wins, nothing starts
        @(negedge clk);
        bus.cfg_num_tiles = 8'd1; bus.start = 1'b1; bus.abort = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.abort = 1'b0;
            check("sa_busy", n, longint'(bus.busy), 64'd0);
            check("sa_wgt_en", n, longint'(bus.wgt_mem_read_EN), 64'd0);
            check("sa_done", n, longint'(bus.done), 64'd0);
        end

        // asynchronous reset in the middle of LOAD_WGT
        @(negedge clk);
        bus.cfg_num_tiles = 8'd1; bus.cfg_wgt_base = 13'h100; bus.cfg_accumulate = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre_rst_wgt", 2, port_val(0), 64'h1_0000_0101);
        check("pre_rst_bpath", 2, longint'(bus.b_path_en), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 2, longint'(bus.busy), 64'd0);
        check("arst_wgt", 2, port_val(0), 64'd0);
        check("arst_bpath", 2, longint'(bus.b_path_en), 64'd0);
        check("arst_acc_add", 2, longint'(bus.acc_add_en), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            check("post_rst_done", n, longint'(bus.done), 64'd0);
            check("post_rst_busy", n, longint'(bus.busy), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
